// File: rtl/arm_fetch_stage.sv
// arm_fetch_stage: PC owner and IF/ID register with redirect, freeze and memory-wait handling.
module arm_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);
  logic [31:0] r_pc, r_instr, r_if_pc, r_fetch, r_stall;
  logic        r_valid;
  logic [31:0] w_pc_next;
  assign w_pc_next   = r_pc + 32'd4;
  assign imem_addr   = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_if_pc;
  assign if_id_valid = r_valid;
  assign fetch_count = r_fetch;
  assign stall_count = r_stall;
  // Priority: redirect > freeze > memory wait > advance.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_if_pc <= '0;
      r_valid <= 1'b0;
      r_fetch <= '0;
      r_stall <= '0;
    end else if (branch_taken) begin
      r_pc    <= {branch_addr[31:2], 2'b00};
      r_instr <= '0;
      r_if_pc <= '0;
      r_valid <= 1'b0;
    end else if (freeze) begin
      r_stall <= r_stall + 32'd1;
    end else if (!imem_ready) begin
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_instr <= imem_data;
      r_if_pc <= w_pc_next;
      r_valid <= 1'b1;
      r_fetch <= r_fetch + 32'd1;
    end
endmodule

// File: tb/tb_arm_fetch_stage.sv
// tb_arm_fetch_stage: directed scenario tests for the fetch stage.
module tb_arm_fetch_stage;
  logic        clk, rst, rst2, imem_ready, freeze, branch_taken;
  logic [31:0] branch_addr, imem_addr, imem_data, if_id_instr, if_id_pc, fetch_count, stall_count;
  logic [31:0] imem_addr2, imem_data2, if_id_instr2, if_id_pc2, fetch_count2, stall_count2;
  logic        if_id_valid, if_id_valid2;
  int checks = 0, errors = 0;

  arm_fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
    .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  arm_fetch_stage #(.RESET_PC(32'h0000_0100)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_data(imem_data2), .imem_ready(imem_ready),
    .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2), .if_id_valid(if_id_valid2),
    .fetch_count(fetch_count2), .stall_count(stall_count2)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h0 ? 32'hE3A0_0014 : a == 32'h4 ? 32'hE3A0_1A01 :
           a == 32'h8 ? 32'hE3A0_2103 : {8'hA5, a[23:0]};
  endfunction

  assign imem_data  = word(imem_addr);
  assign imem_data2 = word(imem_addr2);

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rst2 = 1; imem_ready = 1; freeze = 0; branch_taken = 0; branch_addr = 0;
    step(); step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp %h", imem_addr, 32'h0); end
    checks++; if (imem_addr2 !== 32'h100) begin errors++; $display("FAIL reset_addr2: got %h exp %h", imem_addr2, 32'h100); end
    checks++; if ({if_id_valid, if_id_instr, if_id_pc} !== 65'h0) begin errors++; $display("FAIL reset_ifid: got %b/%h/%h exp 0", if_id_valid, if_id_instr, if_id_pc); end
    checks++; if ({fetch_count, stall_count} !== 64'h0) begin errors++; $display("FAIL reset_counts: got %h/%h exp 0", fetch_count, stall_count); end
    rst = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'hE3A0_0014; exp_i[1] = 32'hE3A0_1A01; exp_i[2] = 32'hE3A0_2103;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h exp %h", i, imem_addr, 4 * i); end
      step();
      checks++; if (if_id_instr !== exp_i[i] || if_id_pc !== 32'(4 * i + 4) || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL seq_ifid%0d: got %h/%h/%b exp %h/%h/1", i, if_id_instr, if_id_pc, if_id_valid, exp_i[i], 4 * i + 4); end
    end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d exp 3", fetch_count); end
  endtask

  task automatic test_freeze();
    step();
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h10 || if_id_instr !== word(32'hC) || if_id_pc !== 32'h10 || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL freeze_hold%0d: got %h/%h/%h/%b exp 10/%h/10/1", i, imem_addr, if_id_instr, if_id_pc, if_id_valid, word(32'hC)); end
    end
    checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL freeze_stalls: got %0d exp 3", stall_count); end
    freeze = 0;
    step();
    checks++; if (if_id_instr !== word(32'h10) || if_id_pc !== 32'h14 || fetch_count !== 32'd5) begin
      errors++; $display("FAIL freeze_release: got %h/%h/%0d exp %h/14/5", if_id_instr, if_id_pc, fetch_count, word(32'h10)); end
  endtask

  task automatic test_wait();
    step(); step(); step();
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL wait_setup: got %h exp 20", imem_addr); end
    imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_addr !== 32'h20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h20) begin
        errors++; $display("FAIL wait_bubble%0d: got %h/%b/%h/%h exp 20/0/0/20", i, imem_addr, if_id_valid, if_id_instr, if_id_pc); end
    end
    imem_ready = 1;
    step();
    checks++; if (if_id_instr !== word(32'h20) || if_id_pc !== 32'h24 || if_id_valid !== 1'b1 || fetch_count !== 32'd9) begin
      errors++; $display("FAIL wait_resume: got %h/%h/%b/%0d exp %h/24/1/9", if_id_instr, if_id_pc, if_id_valid, fetch_count, word(32'h20)); end
  endtask

  task automatic test_branch();
    step();
    checks++; if (imem_addr !== 32'h28) begin errors++; $display("FAIL branch_setup: got %h exp 28", imem_addr); end
    branch_taken = 1; branch_addr = 32'h70;
    step();
    branch_taken = 0;
    checks++; if (imem_addr !== 32'h70 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 || fetch_count !== 32'd10) begin
      errors++; $display("FAIL branch_bubble: got %h/%b/%h/%h/%0d exp 70/0/0/0/10", imem_addr, if_id_valid, if_id_instr, if_id_pc, fetch_count); end
    step();
    checks++; if (if_id_pc !== 32'h74 || if_id_valid !== 1'b1 || if_id_instr !== word(32'h70)) begin
      errors++; $display("FAIL branch_target: got %h/%b/%h exp 74/1/%h", if_id_pc, if_id_valid, if_id_instr, word(32'h70)); end
  endtask

  task automatic test_priority();
    freeze = 1; branch_taken = 1; imem_ready = 0; branch_addr = 32'h43;
    step();
    freeze = 0; branch_taken = 0; imem_ready = 1;
    checks++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || stall_count !== 32'd3) begin
      errors++; $display("FAIL priority: got %h/%b/%0d exp 40/0/3", imem_addr, if_id_valid, stall_count); end
  endtask

  task automatic test_back_to_back();
    branch_taken = 1; branch_addr = 32'h80;
    step();
    checks++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h/%b exp 80/0", imem_addr, if_id_valid); end
    branch_addr = 32'h90;
    step();
    branch_taken = 0;
    checks++; if (imem_addr !== 32'h90 || if_id_valid !== 1'b0) begin errors++; $display("FAIL b2b_second: got %h/%b exp 90/0", imem_addr, if_id_valid); end
    step();
    checks++; if (if_id_pc !== 32'h94 || if_id_instr !== word(32'h90) || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_target: got %h/%h/%b exp 94/%h/1", if_id_pc, if_id_instr, if_id_valid, word(32'h90)); end
  endtask

  task automatic test_wrap();
    branch_taken = 1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h exp fffffffc", imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h0 || if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap: got %h/%h/%b/%h exp 0/0/1/%h", imem_addr, if_id_pc, if_id_valid, if_id_instr, word(32'hFFFF_FFFC)); end
  endtask

  task automatic test_async_reset();
    rst2 = 0; freeze = 1;
    step();
    checks++; if (imem_addr2 !== 32'h100 || stall_count2 !== 32'd1) begin errors++; $display("FAIL areset_setup2: got %h/%0d exp 100/1", imem_addr2, stall_count2); end
    #2 rst = 1; rst2 = 1;
    #1;
    checks++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 || fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      errors++; $display("FAIL areset_dut: got %h/%b/%h/%h/%h/%h exp all 0", imem_addr, if_id_valid, if_id_instr, if_id_pc, fetch_count, stall_count); end
    checks++; if (imem_addr2 !== 32'h100 || stall_count2 !== 32'h0 || if_id_valid2 !== 1'b0) begin
      errors++; $display("FAIL areset_dut2: got %h/%0d/%b exp 100/0/0", imem_addr2, stall_count2, if_id_valid2); end
    #2 rst = 0; rst2 = 0; freeze = 0;
    step();
    checks++; if (if_id_pc2 !== 32'h104 || if_id_instr2 !== word(32'h100) || if_id_valid2 !== 1'b1 || fetch_count2 !== 32'd1) begin
      errors++; $display("FAIL areset_first2: got %h/%h/%b/%0d exp 104/%h/1/1", if_id_pc2, if_id_instr2, if_id_valid2, fetch_count2, word(32'h100)); end
    checks++; if (if_id_pc !== 32'h4 || if_id_instr !== 32'hE3A0_0014) begin
      errors++; $display("FAIL areset_first: got %h/%h exp 4/e3a00014", if_id_pc, if_id_instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_freeze();
    test_wait();
    test_branch();
    test_priority();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arm_fetch_stage.md
# arm_fetch_stage

Instruction-fetch stage of the ARM pipeline. It is the initiator side of the instruction-memory interface. It owns the program counter and drives a word address to the instruction memory. It captures the returned instruction into the IF/ID pipeline register. It also applies branch redirects, hazard freezes and memory wait states. It sits between the instruction memory and the decode stage, and takes redirect/freeze controls from EX and the hazard unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals pc, combinational from the pc register.
- imem_data  input  32  instruction word returned for imem_addr, valid in the same cycle.
- imem_ready  input  1  memory has imem_data valid this cycle; tie high for the single-cycle memory.
- freeze  input  1  hazard stall from the hazard unit; hold pc and IF/ID.
- branch_taken  input  1  redirect from EX; flush IF/ID and load pc.
- branch_addr  input  32  absolute branch target from EX; bits [1:0] ignored (forced 0).
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc  output  32  registered fetch PC + 4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.
- stall_count  output  32  number of cycles with freeze=1 and branch_taken=0 since reset.

## Operation
- State: pc, if_id_instr, if_id_pc, if_id_valid, fetch_count, stall_count.
- Per-edge action uses fixed priority; exactly one row applies:
  - branch_taken=1 (REDIRECT): pc <= {branch_addr[31:2],2'b00}. if_id_valid <= 0, if_id_instr <= 0, if_id_pc <= 0. Branch overrides freeze and imem_ready.
  - freeze=1 (HOLD): pc and all IF/ID fields unchanged. stall_count += 1.
  - imem_ready=0 (WAIT): pc unchanged. if_id_valid <= 0, if_id_instr <= 0. if_id_pc is unchanged.
  - otherwise (ADVANCE): pc <= pc + 4. if_id_instr <= imem_data. if_id_pc <= pc + 4. if_id_valid <= 1. fetch_count += 1.
- Arithmetic: all adds are 32-bit modulo. pc at 32'hFFFF_FFFC advances to 0 with no flag. Counters wrap from 32'hFFFF_FFFF to 0.
- A branch whose target is the current pc (self-loop, encoding 32'hEAFF_FFFF style) is legal. It fetches repeatedly; no halt detection.
- Reset, asynchronous at any time including mid-freeze or mid-redirect:
  - pc = RESET_PC.
  - if_id_instr = 0, if_id_pc = 0, if_id_valid = 0.
  - fetch_count = 0, stall_count = 0.
  - imem_addr = RESET_PC immediately.
- The stage decodes no instruction fields; condition codes and branch resolution belong to later stages.

## Timing
- imem_addr is a zero-latency function of the pc register; there is no combinational path from any input to imem_addr.
- Fetch latency: the word at pc appears on if_id_instr one edge after the cycle in which it is addressed with imem_ready=1.
- Redirect penalty:
  - branch_taken sampled high at edge E produces a bubble (valid=0) for the cycle after E.
  - The target instruction appears with valid=1 after edge E+1 (imem_ready=1, freeze=0).
  - The instruction fetched in the branch cycle is discarded.
- Freeze holds indefinitely; on release, fetch resumes from the held pc with no instruction lost or duplicated.
- Back-to-back branches on consecutive edges: the last one wins. if_id_valid stays 0 throughout.
- Deassertion of rst: the first ADVANCE can occur on the first rising edge after release.

## Test plan
- Reset then free-run with memory holding E3A00014, E3A01A01, E3A02103:
  - imem_addr sequence 0, 4, 8.
  - if_id_instr E3A00014 / if_id_pc 4, then E3A01A01 / 8, then E3A02103 / 12.
  - fetch_count = 3.
- Branch: branch_taken=1 with branch_addr=32'h0000_0070 while pc=0x28:
  - next cycle imem_addr=0x70 and if_id_valid=0;
  - following cycle if_id_pc=0x74 and valid=1.
- Freeze for 3 cycles at pc=0x10 with IF/ID holding the word from 0x0C:
  - pc stays 0x10 and IF/ID is unchanged;
  - stall_count += 3;
  - after release, the next if_id_instr = mem[0x10].
- Simultaneous freeze=1, branch_taken=1, imem_ready=0, branch_addr=0x43: pc <= 0x40, valid=0, stall_count unchanged.
- imem_ready low for 2 cycles at pc=0x20: two bubbles, pc stays 0x20; then mem[0x20] is captured with if_id_pc=0x24.
- Assert rst asynchronously mid-clock during a freeze:
  - all outputs go to reset values before the next edge;
  - with RESET_PC=0x100 the first fetched if_id_pc is 0x104.
- Wrap: branch to 0xFFFF_FFFC, then advance; next imem_addr = 0 and if_id_pc = 0.
